// File: rtl/axil_simd_pkg.sv
// Shared types for the AXI-lite SIMD broadcasters: one-hot FSM encoding,
// AXI response codes and the worst-response merge.
package axil_simd_pkg;

  localparam int ST_IDLE_B  = 0;
  localparam int ST_ISSUE_B = 1;
  localparam int ST_RESP_B  = 2;
  localparam int ST_BRSP_B  = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_RESP  = 4'b0100,
    ST_BRSP  = 4'b1000
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Response codes are ordered by severity, so the worst is the numeric max.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/axil_simd_wr_lane.sv
// Per-master write lane: tracks AW, W and B handshakes for one master port.
// Latency: valids one cycle after start, bready one cycle after AW and W both complete.
// Backpressure: valids hold until each master's own ready; bready holds until bvalid.
module axil_simd_wr_lane
  import axil_simd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear,
  input  logic       awready,
  input  logic       wready,
  input  logic       bvalid,
  input  logic [1:0] bresp,
  output logic       awvalid,
  output logic       wvalid,
  output logic       bready,
  output logic       complete,
  output logic [1:0] resp
);

  logic       pending;
  logic       done_q;
  logic [1:0] resp_q;
  logic       aw_fin;
  logic       w_fin;

  assign aw_fin = ~awvalid | awready;
  assign w_fin  = ~wvalid | wready;

  // Includes a response landing this cycle so the merge can happen on the same edge.
  assign complete = done_q | (bready & bvalid);
  assign resp     = done_q ? resp_q : bresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      pending <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else if (start) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      bready  <= 1'b0;
      pending <= 1'b1;
      done_q  <= 1'b0;
    end else if (clear) begin
      bready  <= 1'b0;
      pending <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (bready && bvalid) begin
        bready <= 1'b0;
        done_q <= 1'b1;
        resp_q <= bresp;
      end else if (pending && !done_q && !bready && aw_fin && w_fin) begin
        bready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axil_simd_wr.sv
// AXI-lite write broadcaster; AXIL_SIMD_WR_RESP_MERGE_EN returns the worst master response.
// Latency: masters see AW/W 1 cycle after acceptance, s_bvalid 3 cycles after (masters ready).
// Backpressure: one write outstanding; slave readys stay low until the merged B is taken.
module axil_simd_wr
  import axil_simd_pkg::*;
#(
  parameter int M_COUNT    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  output logic [M_COUNT*ADDR_WIDTH-1:0]  m_axil_awaddr,
  output logic [M_COUNT*3-1:0]           m_axil_awprot,
  output logic [M_COUNT-1:0]             m_axil_awvalid,
  input  logic [M_COUNT-1:0]             m_axil_awready,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axil_wdata,
  output logic [M_COUNT*STRB_WIDTH-1:0]  m_axil_wstrb,
  output logic [M_COUNT-1:0]             m_axil_wvalid,
  input  logic [M_COUNT-1:0]             m_axil_wready,
  input  logic [M_COUNT*2-1:0]           m_axil_bresp,
  input  logic [M_COUNT-1:0]             m_axil_bvalid,
  output logic [M_COUNT-1:0]             m_axil_bready
);

  state_t                    state, state_d;
  logic                      aw_held, aw_held_d;
  logic                      w_held, w_held_d;
  logic                      awready_d, wready_d;
  logic                      bvalid_d;
  logic [1:0]                bresp_d;
  logic                      start, clear;
  logic                      aw_hs, w_hs;
  logic                      issue_clear, all_done;
  logic [M_COUNT-1:0]        lane_complete;
  logic [M_COUNT-1:0][1:0]   lane_resp;
  logic [1:0]                merged;
  logic [ADDR_WIDTH-1:0]     awaddr_q;
  logic [2:0]                awprot_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;

  assign aw_hs       = s_axil_awvalid & s_axil_awready;
  assign w_hs        = s_axil_wvalid & s_axil_wready;
  assign issue_clear = ~|(m_axil_awvalid | m_axil_wvalid);
  assign all_done    = &lane_complete;

  always_comb begin
    merged = RESP_OKAY;
    for (int i = 0; i < M_COUNT; i++) begin
`ifdef AXIL_SIMD_WR_RESP_MERGE_EN
      merged = resp_worst(merged, lane_resp[i]);
`else
      if (i == 0) merged = lane_resp[i];
`endif
    end
  end

  always_comb begin
    state_d   = state;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    bvalid_d  = s_axil_bvalid;
    bresp_d   = s_axil_bresp;
    start     = 1'b0;
    clear     = 1'b0;
    case (1'b1)
      state[ST_IDLE_B]: begin
        aw_held_d = aw_held | aw_hs;
        w_held_d  = w_held | w_hs;
        if (aw_held_d && w_held_d) begin
          start   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      // A lane can only finish once its valids are gone, so all_done implies issue_clear.
      state[ST_ISSUE_B], state[ST_RESP_B]: begin
        if (all_done) begin
          bvalid_d = 1'b1;
          bresp_d  = merged;
          state_d  = ST_BRSP;
        end else if (issue_clear) begin
          state_d = ST_RESP;
        end
      end
      state[ST_BRSP_B]: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          clear     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    awready_d = state_d[ST_IDLE_B] & ~aw_held_d;
    wready_d  = state_d[ST_IDLE_B] & ~w_held_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      state          <= state_d;
      aw_held        <= aw_held_d;
      w_held         <= w_held_d;
      s_axil_awready <= awready_d;
      s_axil_wready  <= wready_d;
      s_axil_bvalid  <= bvalid_d;
      s_axil_bresp   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      awaddr_q <= s_axil_awaddr;
      awprot_q <= s_axil_awprot;
    end
    if (w_hs) begin
      wdata_q <= s_axil_wdata;
      wstrb_q <= s_axil_wstrb;
    end
  end

  assign m_axil_awaddr = {M_COUNT{awaddr_q}};
  assign m_axil_awprot = {M_COUNT{awprot_q}};
  assign m_axil_wdata  = {M_COUNT{wdata_q}};
  assign m_axil_wstrb  = {M_COUNT{wstrb_q}};

  for (genvar g = 0; g < M_COUNT; g++) begin : g_lane
    axil_simd_wr_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .clear    (clear),
      .awready  (m_axil_awready[g]),
      .wready   (m_axil_wready[g]),
      .bvalid   (m_axil_bvalid[g]),
      .bresp    (m_axil_bresp[2*g +: 2]),
      .awvalid  (m_axil_awvalid[g]),
      .wvalid   (m_axil_wvalid[g]),
      .bready   (m_axil_bready[g]),
      .complete (lane_complete[g]),
      .resp     (lane_resp[g])
    );
  end

endmodule

// File: tb/tb_axil_simd_wr.sv
// Directed bench for axil_simd_wr with four behavioural register-slave masters.
module tb_axil_simd_wr;
  import axil_simd_pkg::*;

  localparam int MC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    s_axil_awaddr;
  logic [2:0]       s_axil_awprot;
  logic             s_axil_awvalid;
  logic             s_axil_awready;
  logic [DW-1:0]    s_axil_wdata;
  logic [SW-1:0]    s_axil_wstrb;
  logic             s_axil_wvalid;
  logic             s_axil_wready;
  logic [1:0]       s_axil_bresp;
  logic             s_axil_bvalid;
  logic             s_axil_bready;
  logic [MC*AW-1:0] m_axil_awaddr;
  logic [MC*3-1:0]  m_axil_awprot;
  logic [MC-1:0]    m_axil_awvalid;
  logic [MC-1:0]    m_axil_awready;
  logic [MC*DW-1:0] m_axil_wdata;
  logic [MC*SW-1:0] m_axil_wstrb;
  logic [MC-1:0]    m_axil_wvalid;
  logic [MC-1:0]    m_axil_wready;
  logic [MC*2-1:0]  m_axil_bresp;
  logic [MC-1:0]    m_axil_bvalid;
  logic [MC-1:0]    m_axil_bready;

  axil_simd_wr #(.M_COUNT(MC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready)
  );

  int total = 0;
  int bad = 0;

  // Master model configuration and observation.
  int         aw_dly[MC], w_dly[MC], b_dly[MC];
  logic [1:0] bresp_cfg[MC];
  int         aw_wait[MC], w_wait[MC], b_wait[MC];
  bit         aw_seen[MC], w_seen[MC], b_fire[MC];
  int         aw_cnt[MC], w_cnt[MC], b_cnt[MC];

  // Readys and responses change on the falling edge; a handshake counted here
  // completes on the following rising edge.
  initial begin
    m_axil_awready = '0;
    m_axil_wready  = '0;
    m_axil_bvalid  = '0;
    m_axil_bresp   = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < MC; i++) begin
        if (!rst_n) begin
          m_axil_awready[i] = 1'b0;
          m_axil_wready[i]  = 1'b0;
          m_axil_bvalid[i]  = 1'b0;
          aw_wait[i] = 0; w_wait[i] = 0; b_wait[i] = 0;
          aw_seen[i] = 1'b0; w_seen[i] = 1'b0; b_fire[i] = 1'b0;
        end else begin
          if (b_fire[i]) begin
            m_axil_bvalid[i] = 1'b0;
            b_fire[i] = 1'b0;
          end
          if (!m_axil_bvalid[i] && aw_seen[i] && w_seen[i]) begin
            if (b_wait[i] >= b_dly[i]) begin
              m_axil_bvalid[i] = 1'b1;
              m_axil_bresp[2*i +: 2] = bresp_cfg[i];
              aw_seen[i] = 1'b0; w_seen[i] = 1'b0; b_wait[i] = 0;
            end else begin
              b_wait[i]++;
            end
          end
          if (m_axil_bvalid[i] && m_axil_bready[i]) begin
            b_fire[i] = 1'b1;
            b_cnt[i]++;
          end
          if (m_axil_awvalid[i]) begin
            if (aw_wait[i] >= aw_dly[i]) m_axil_awready[i] = 1'b1;
            else begin m_axil_awready[i] = 1'b0; aw_wait[i]++; end
          end else begin
            m_axil_awready[i] = 1'b0; aw_wait[i] = 0;
          end
          if (m_axil_awvalid[i] && m_axil_awready[i]) begin aw_cnt[i]++; aw_seen[i] = 1'b1; end
          if (m_axil_wvalid[i]) begin
            if (w_wait[i] >= w_dly[i]) m_axil_wready[i] = 1'b1;
            else begin m_axil_wready[i] = 1'b0; w_wait[i]++; end
          end else begin
            m_axil_wready[i] = 1'b0; w_wait[i] = 0;
          end
          if (m_axil_wvalid[i] && m_axil_wready[i]) begin w_cnt[i]++; w_seen[i] = 1'b1; end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic clear_model();
    for (int i = 0; i < MC; i++) begin
      aw_dly[i] = 0; w_dly[i] = 0; b_dly[i] = 0; bresp_cfg[i] = RESP_OKAY;
      aw_cnt[i] = 0; w_cnt[i] = 0; b_cnt[i] = 0;
    end
  endtask

  function automatic bit counts_one();
    bit r = 1'b1;
    for (int i = 0; i < MC; i++)
      if (aw_cnt[i] != 1 || w_cnt[i] != 1 || b_cnt[i] != 1) r = 1'b0;
    return r;
  endfunction

  // Runs whatever slave valids are raised until each has handshaken.
  task automatic drive_hs(output bit ok);
    int n = 0;
    bit aw_go, w_go;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 50) begin
      aw_go = s_axil_awvalid && s_axil_awready;
      w_go  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      if (aw_go) s_axil_awvalid = 1'b0;
      if (w_go)  s_axil_wvalid  = 1'b0;
      n++;
    end
    ok = !(s_axil_awvalid || s_axil_wvalid);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
  endtask

  task automatic put_both(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                          input logic [3:0] s, output bit ok);
    s_axil_awaddr = a; s_axil_awprot = p; s_axil_awvalid = 1'b1;
    s_axil_wdata = d;  s_axil_wstrb = s;  s_axil_wvalid = 1'b1;
    drive_hs(ok);
  endtask

  task automatic wait_bvalid(output int n, output bit ok);
    n = 0;
    while (!s_axil_bvalid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = s_axil_bvalid;
  endtask

  task automatic bresp_hs();
    s_axil_bready = 1'b1;
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (m_axil_awvalid !== '0 || m_axil_wvalid !== '0 || m_axil_bready !== '0)
      begin bad++; $display("FAIL reset_mvalid: aw=%h w=%h b=%h want 0", m_axil_awvalid, m_axil_wvalid, m_axil_bready); end
    total++;
    if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0 || s_axil_bvalid !== 1'b0 || s_axil_bresp !== 2'b00)
      begin bad++; $display("FAIL reset_slave: awr=%b wr=%b bv=%b br=%b want 0", s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1)
      begin bad++; $display("FAIL reset_release_rdy: awr=%b wr=%b want 1/1", s_axil_awready, s_axil_wready); end
  endtask

  task automatic test_single();
    bit ok;
    logic [MC*AW-1:0] exp_a = {MC{32'h0000_0100}};
    logic [MC*3-1:0]  exp_p = {MC{3'b010}};
    logic [MC*DW-1:0] exp_d = {MC{32'hDEAD_BEEF}};
    logic [MC*SW-1:0] exp_s = {MC{4'hF}};
    clear_model();
    put_both(32'h100, 3'b010, 32'hDEADBEEF, 4'hF, ok);
    total++;
    if (!ok || m_axil_awvalid !== 4'hF || m_axil_wvalid !== 4'hF)
      begin bad++; $display("FAIL single_mvalid: ok=%b aw=%h w=%h want 1/f/f", ok, m_axil_awvalid, m_axil_wvalid); end
    total++;
    if (m_axil_awaddr !== exp_a || m_axil_awprot !== exp_p)
      begin bad++; $display("FAIL single_addr: addr=%h prot=%h want %h %h", m_axil_awaddr, m_axil_awprot, exp_a, exp_p); end
    total++;
    if (m_axil_wdata !== exp_d || m_axil_wstrb !== exp_s)
      begin bad++; $display("FAIL single_data: data=%h strb=%h want %h %h", m_axil_wdata, m_axil_wstrb, exp_d, exp_s); end
    total++;
    if (s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0)
      begin bad++; $display("FAIL single_rdy_low: awr=%b wr=%b want 0/0", s_axil_awready, s_axil_wready); end
    @(posedge clk); #1;
    total++;
    if (m_axil_bready !== 4'hF || s_axil_bvalid !== 1'b0)
      begin bad++; $display("FAIL single_bready: bready=%h bv=%b want f/0", m_axil_bready, s_axil_bvalid); end
    @(posedge clk); #1;
    total++;
    if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== RESP_OKAY)
      begin bad++; $display("FAIL single_bvalid: bv=%b br=%b want 1/00", s_axil_bvalid, s_axil_bresp); end
    bresp_hs();
    total++;
    if (!counts_one())
      begin bad++; $display("FAIL single_counts: m0 aw=%0d w=%0d b=%0d want 1 each on all masters", aw_cnt[0], w_cnt[0], b_cnt[0]); end
    total++;
    if (s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1)
      begin bad++; $display("FAIL single_reopen: bv=%b awr=%b wr=%b want 0/1/1", s_axil_bvalid, s_axil_awready, s_axil_wready); end
  endtask

  task automatic test_w_first();
    bit ok, quiet;
    int n;
    logic [MC*DW-1:0] exp_d = {MC{32'hCAFE_F00D}};
    logic [MC*SW-1:0] exp_s = {MC{4'h3}};
    logic [MC*AW-1:0] exp_a = {MC{32'h0000_0104}};
    clear_model();
    s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'h3; s_axil_wvalid = 1'b1;
    drive_hs(ok);
    quiet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (m_axil_awvalid !== '0 || m_axil_wvalid !== '0 || s_axil_wready !== 1'b0 || s_axil_awready !== 1'b1)
        quiet = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (!ok || !quiet)
      begin bad++; $display("FAIL wfirst_hold: ok=%b quiet=%b want 1/1", ok, quiet); end
    s_axil_awaddr = 32'h104; s_axil_awprot = 3'b000; s_axil_awvalid = 1'b1;
    drive_hs(ok);
    total++;
    if (!ok || m_axil_awvalid !== 4'hF || m_axil_wdata !== exp_d || m_axil_wstrb !== exp_s || m_axil_awaddr !== exp_a)
      begin bad++; $display("FAIL wfirst_bcast: ok=%b aw=%h data=%h strb=%h want f %h %h", ok, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, exp_d, exp_s); end
    wait_bvalid(n, ok);
    total++;
    if (!ok || n != 2 || s_axil_bresp !== RESP_OKAY)
      begin bad++; $display("FAIL wfirst_resp: ok=%b cycles=%0d br=%b want 1/2/00", ok, n, s_axil_bresp); end
    bresp_hs();
  endtask

  task automatic test_skew();
    bit ok;
    int n;
    clear_model();
    w_dly[2] = 5;
    b_dly[0] = 7;
    put_both(32'h108, 3'b001, 32'h0BAD_F00D, 4'hC, ok);
    total++;
    if (!ok || m_axil_wvalid !== 4'hF)
      begin bad++; $display("FAIL skew_issue: ok=%b w=%h want 1/f", ok, m_axil_wvalid); end
    wait_bvalid(n, ok);
    total++;
    if (!ok || n != 9)
      begin bad++; $display("FAIL skew_latency: ok=%b cycles=%0d want 1/9", ok, n); end
    bresp_hs();
    total++;
    if (!counts_one())
      begin bad++; $display("FAIL skew_counts: m0 b=%0d m2 w=%0d want 1 each on all masters", b_cnt[0], w_cnt[2]); end
    total++;
    if (m_axil_bready !== '0 || m_axil_awvalid !== '0 || m_axil_wvalid !== '0)
      begin bad++; $display("FAIL skew_idle: bready=%h aw=%h w=%h want 0", m_axil_bready, m_axil_awvalid, m_axil_wvalid); end
  endtask

  task automatic test_resp();
    bit ok;
    int n;
    logic [1:0] exp1, exp2;
`ifdef AXIL_SIMD_WR_RESP_MERGE_EN
    exp1 = RESP_SLVERR; exp2 = RESP_DECERR;
`else
    exp1 = RESP_OKAY;   exp2 = RESP_OKAY;
`endif
    clear_model();
    bresp_cfg[1] = RESP_SLVERR;
    put_both(32'h10C, 3'b000, 32'h1111_2222, 4'hF, ok);
    wait_bvalid(n, ok);
    total++;
    if (!ok || s_axil_bresp !== exp1)
      begin bad++; $display("FAIL resp_slverr: ok=%b br=%b want %b", ok, s_axil_bresp, exp1); end
    bresp_hs();
    clear_model();
    bresp_cfg[1] = RESP_EXOKAY;
    bresp_cfg[3] = RESP_DECERR;
    put_both(32'h110, 3'b000, 32'h3333_4444, 4'hF, ok);
    wait_bvalid(n, ok);
    total++;
    if (!ok || s_axil_bresp !== exp2)
      begin bad++; $display("FAIL resp_decerr: ok=%b br=%b want %b", ok, s_axil_bresp, exp2); end
    bresp_hs();
  endtask

  task automatic test_bready_stall();
    bit ok, stable;
    int n;
    logic [MC*AW-1:0] exp_a = {MC{32'h0000_0204}};
    clear_model();
    bresp_cfg[0] = RESP_SLVERR;
    bresp_cfg[2] = RESP_EXOKAY;
    put_both(32'h200, 3'b000, 32'h5555_6666, 4'hF, ok);
    wait_bvalid(n, ok);
    s_axil_awaddr = 32'h204; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h7777_8888; s_axil_wvalid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== RESP_SLVERR || s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0)
        stable = 1'b0;
      @(posedge clk); #1;
    end
    total++;
    if (!ok || !stable)
      begin bad++; $display("FAIL stall_hold: ok=%b stable=%b want 1/1", ok, stable); end
    bresp_hs();
    total++;
    if (s_axil_bvalid !== 1'b0 || s_axil_awready !== 1'b1 || s_axil_wready !== 1'b1 || m_axil_awvalid !== '0)
      begin bad++; $display("FAIL stall_release: bv=%b awr=%b wr=%b aw=%h want 0/1/1/0", s_axil_bvalid, s_axil_awready, s_axil_wready, m_axil_awvalid); end
    clear_model();
    drive_hs(ok);
    total++;
    if (!ok || m_axil_awvalid !== 4'hF || m_axil_awaddr !== exp_a)
      begin bad++; $display("FAIL stall_next: ok=%b aw=%h addr=%h want f %h", ok, m_axil_awvalid, m_axil_awaddr, exp_a); end
    wait_bvalid(n, ok);
    bresp_hs();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [MC*DW-1:0] exp_d = {MC{32'h1234_5678}};
    clear_model();
    for (int i = 0; i < MC; i++) aw_dly[i] = 20;
    put_both(32'h300, 3'b000, 32'h9999_AAAA, 4'hF, ok);
    @(posedge clk); #1;
    total++;
    if (!ok || m_axil_awvalid !== 4'hF)
      begin bad++; $display("FAIL rstmid_issue: ok=%b aw=%h want 1/f", ok, m_axil_awvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (m_axil_awvalid !== '0 || m_axil_wvalid !== '0 || m_axil_bready !== '0 ||
        s_axil_awready !== 1'b0 || s_axil_wready !== 1'b0 || s_axil_bvalid !== 1'b0)
      begin bad++; $display("FAIL rstmid_async: aw=%h w=%h b=%h awr=%b wr=%b bv=%b want 0", m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_axil_awready, s_axil_wready, s_axil_bvalid); end
    @(negedge clk);
    @(negedge clk);
    clear_model();
    rst_n = 1'b1;
    @(posedge clk); #1;
    put_both(32'h304, 3'b000, 32'h1234_5678, 4'hF, ok);
    total++;
    if (!ok || m_axil_wdata !== exp_d)
      begin bad++; $display("FAIL rstmid_fresh: ok=%b data=%h want %h", ok, m_axil_wdata, exp_d); end
    wait_bvalid(n, ok);
    total++;
    if (!ok || n != 2 || s_axil_bresp !== RESP_OKAY)
      begin bad++; $display("FAIL rstmid_resp: ok=%b cycles=%0d br=%b want 1/2/00", ok, n, s_axil_bresp); end
    bresp_hs();
    total++;
    if (!counts_one())
      begin bad++; $display("FAIL rstmid_counts: m0 aw=%0d w=%0d b=%0d want 1 each on all masters", aw_cnt[0], w_cnt[0], b_cnt[0]); end
  endtask

  initial begin
    s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0;  s_axil_wstrb = '0;  s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0;
    clear_model();
    test_reset();
    test_single();
    test_w_first();
    test_skew();
    test_resp();
    test_bready_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_simd_wr.md
# axil_simd_wr

AXI4-lite write broadcaster: accepts one write on a single slave port and replicates it to M_COUNT master ports, then waits for every master's write response and returns one merged response upstream. It is the write-side companion of the SIMD read broadcaster and sits between one AXI-lite initiator and a bank of identical register slaves that must be written in lockstep. One write is outstanding at a time.

## Interface
- M_COUNT, 8, number of master interfaces (1..32)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 or 64)
- STRB_WIDTH, DATA_WIDTH/8, strobe width; must equal DATA_WIDTH/8

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axil_awaddr / awprot / awvalid / awready  in/in/in/out  ADDR_WIDTH/3/1/1  slave write address
- s_axil_wdata / wstrb / wvalid / wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  slave write data
- s_axil_bresp / bvalid / bready  out/out/in  2/1/1  slave write response
- m_axil_awaddr / awprot  out  M_COUNT*ADDR_WIDTH / M_COUNT*3  replicated address and prot
- m_axil_awvalid / awready  out/in  M_COUNT each  per-master address handshake
- m_axil_wdata / wstrb  out  M_COUNT*DATA_WIDTH / M_COUNT*STRB_WIDTH  replicated data and strobe
- m_axil_wvalid / wready  out/in  M_COUNT each  per-master data handshake
- m_axil_bresp  in  M_COUNT*2  per-master response
- m_axil_bvalid / bready  in/out  M_COUNT each  per-master response handshake

## Operation
- States (one-hot): IDLE, ISSUE, RESP, BRSP.
- IDLE: s_axil_awready high while no AW is held; s_axil_wready high while no W is held. AW and W are captured independently, in either order or in the same cycle. Once both are held: load the per-master address, prot, data and strobe registers, set all m_awvalid and m_wvalid, and go to ISSUE. Both slave readys are low from that point.
- ISSUE: each master's awvalid clears on its own awready. Each master's wvalid clears on its own wready. Masters are tracked independently. m_bready[i] rises once that master's AW and W have both completed. When every awvalid and wvalid is clear, go to RESP.
- RESP (m_bready is also honoured during late ISSUE): on m_bvalid[i] && m_bready[i], capture the response, clear bready[i] and set done[i]. When done is all ones, load s_bresp, set s_bvalid, and go to BRSP.
- BRSP: hold s_bvalid and s_bresp until s_bready. On that handshake: clear s_bvalid, clear the held AW/W flags and done, re-enable the slave readys, and go to IDLE.
- Once the response is merged, a master raising bvalid again is ignored (bready stays low).
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Reset values: all valid and ready outputs are 0, s_bresp is 2'b00, state is IDLE, held flags are clear. Address and data registers are don't-care and are not reset.
- First cycle after rst_n deasserts: s_awready and s_wready go to 1.
- Minimum latency, with AW and W in the same cycle at edge N and masters ready immediately:
  - m_awvalid/m_wvalid high in cycle N+1, accepted at edge N+1
  - m_bready high in cycle N+2; bvalid is captured at edge N+2 if present
  - s_bvalid high in cycle N+3
- Back-to-back: the next AW/W is accepted no earlier than the cycle after the s_b handshake.
- Reset asserted mid-transaction: all outputs clear immediately and the transaction is dropped. The masters must be reset together with the block.
- A master that never responds stalls the block indefinitely. There is no timeout.

## Configuration
- AXIL_SIMD_WR_RESP_MERGE_EN defined: s_bresp is the numerically largest captured m_bresp (OKAY < EXOKAY < SLVERR < DECERR).
- Not defined: s_bresp is master 0's response. The other responses are still collected for handshake completion but are discarded.

## Structure
- Shared package axil_simd_pkg holds:
  - state one-hot constants and bit indices
  - AXI response codes
  - worst-response merge function
- Natural sub-module axil_simd_wr_lane, instantiated once per master. It holds awvalid, wvalid, bready and done for that master and outputs an "all complete" flag. The top level reduces these flags with AND.

## Test plan
- Single write, M_COUNT=4, all masters immediately ready and returning OKAY. Stimulus: addr 0x100, data 0xDEADBEEF, strb 0xF. Response: every master sees identical AW/W one cycle after acceptance; s_bresp=0 with s_bvalid three cycles after acceptance.
- W presented 3 cycles before AW → no master valid is asserted until the AW handshake. Then the same write is broadcast with data intact.
- Skewed masters: master 2 wready delayed 5 cycles, master 0 bvalid delayed 7 cycles → each master gets exactly one AW, one W and one B handshake, and s_bvalid waits for the last B.
- Master 1 returns SLVERR, the others OKAY → s_bresp=2'b10 with AXIL_SIMD_WR_RESP_MERGE_EN defined, 2'b00 without it.
- s_bready held low 10 cycles → s_bvalid and s_bresp stay stable, and s_awready/s_wready stay low until the handshake.
- rst_n pulsed low while in ISSUE → all m valids and readys drop asynchronously. After release a fresh write completes normally.
